// File: rtl/mac_stripe_pkg.sv
`default_nettype none
// ============================================================================
// mac_stripe_pkg : mode/state types and sign-magnitude arithmetic helpers
// Revision : 1.0
// ============================================================================
package mac_stripe_pkg;

  localparam int c_WIDE_W = 64;

  typedef logic signed [c_WIDE_W-1:0] wide_t;

  typedef enum logic [1:0] {
    MODE_MAC     = 2'd0,
    MODE_ADD     = 2'd1,
    MODE_SUB     = 2'd2,
    MODE_MAC_ALT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Negative zero collapses to zero because -0 == 0 in two's complement.
  function automatic wide_t sm_to_tc(input logic [c_WIDE_W-1:0] sm, input int w);
    logic [c_WIDE_W-1:0] mag;
    mag = sm & ((64'd1 << (w - 1)) - 64'd1);
    if ((sm & (64'd1 << (w - 1))) != '0)
      return -$signed(mag);
    return $signed(mag);
  endfunction

  function automatic wide_t round_half_away(input wide_t x, input int frac);
    logic [c_WIDE_W-1:0] mag;
    logic [c_WIDE_W-1:0] r;
    mag = x[c_WIDE_W-1] ? -x : x;
    if (frac > 0)
      r = (mag + (64'd1 << (frac - 1))) >> frac;
    else
      r = mag;
    return x[c_WIDE_W-1] ? -$signed(r) : $signed(r);
  endfunction

  function automatic wide_t sat_to(input wide_t x, input int w);
    wide_t hi;
    wide_t lo;
    hi = $signed((64'd1 << (w - 1)) - 64'd1);
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic logic [c_WIDE_W-1:0] tc_to_sm(input wide_t x, input int w);
    logic [c_WIDE_W-1:0] mag;
    logic [c_WIDE_W-1:0] lim;
    lim = (64'd1 << (w - 1)) - 64'd1;
    mag = x[c_WIDE_W-1] ? -x : x;
    if (mag > lim) mag = lim;
    if (x[c_WIDE_W-1]) mag = mag | (64'd1 << (w - 1));
    return mag;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_stripe_lane.sv
`default_nettype none
// ============================================================================
// mac_lane : one lane - operand conversion, op, saturating accumulator, output
// Revision : 1.0
// ============================================================================
module mac_lane
  import mac_stripe_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 14,
  parameter int ACC_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            step,
  input  logic            load_out,
  input  logic [1:0]      mode,
  input  logic [IN_W-1:0] a,
  input  logic [IN_W-1:0] b,
  output logic [IN_W-1:0] out
);

  wide_t                   w_a;
  wide_t                   w_b;
  wide_t                   w_delta;
  wide_t                   w_sum;
  logic signed [ACC_W-1:0] r_acc;
  logic [IN_W-1:0]         r_out;

  always_comb begin
    w_a = sm_to_tc(c_WIDE_W'(a), IN_W);
    w_b = sm_to_tc(c_WIDE_W'(b), IN_W);
    case (mode_e'(mode))
      MODE_ADD: w_delta = w_a + w_b;
      MODE_SUB: w_delta = w_a - w_b;
      default:  w_delta = round_half_away(w_a * w_b, FRAC_W);
    endcase
    w_sum = sat_to(c_WIDE_W'(r_acc) + w_delta, ACC_W);
  end

  // The output snapshot takes the post-update value so the final step is included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_out <= '0;
    end else if (clear) begin
      r_acc <= '0;
      r_out <= '0;
    end else if (step) begin
      r_acc <= ACC_W'(w_sum);
      if (load_out)
        r_out <= IN_W'(tc_to_sm(w_sum, IN_W));
    end
  end

  assign out = r_out;

endmodule
`default_nettype wire

// File: rtl/mac_stripe.sv
`default_nettype none
// ============================================================================
// mac_stripe : tag-matched multi-lane MAC/ADD/SUB engine with config handshake
// Revision : 1.0
// ============================================================================
module mac_stripe
  import mac_stripe_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int IN_W   = 16,
  parameter int FRAC_W = 14,
  parameter int ACC_W  = 32,
  parameter int TAG_W  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [1:0]            cfg_mode,
  input  logic [TAG_W-1:0]      cfg_tag_a,
  input  logic [TAG_W-1:0]      cfg_tag_b,
  input  logic [TAG_W-1:0]      cfg_stride_a,
  input  logic [TAG_W-1:0]      cfg_stride_b,
  input  logic [TAG_W-1:0]      cfg_iter_lim,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [TAG_W-1:0]      a_tag,
  input  logic [LANES*IN_W-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [TAG_W-1:0]      b_tag,
  input  logic [LANES*IN_W-1:0] b_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*IN_W-1:0] out_data,
  output logic                  busy
);

  localparam int c_BUS_W = LANES * IN_W;

  state_e             r_state;
  state_e             w_state_next;
  logic [1:0]         r_mode;
  logic [TAG_W-1:0]   r_tag_a, r_tag_b, r_stride_a, r_stride_b;
  logic [TAG_W-1:0]   r_iter_lim, r_count, w_count_inc;
  logic               r_hold_a, r_hold_b;
  logic [c_BUS_W-1:0] r_a_data, r_b_data;
  logic [c_BUS_W-1:0] w_a_op, w_b_op;
  logic               w_cfg_accept, w_take_a, w_take_b, w_step, w_last;

  // Mismatched tags still complete the handshake; they simply never get held.
  assign w_cfg_accept = (r_state == ST_IDLE) & cfg_valid;
  assign w_take_a     = (r_state == ST_RUN) & ~r_hold_a & a_valid & (a_tag == r_tag_a);
  assign w_take_b     = (r_state == ST_RUN) & ~r_hold_b & b_valid & (b_tag == r_tag_b);
  assign w_step       = (r_state == ST_RUN) & (r_hold_a | w_take_a) & (r_hold_b | w_take_b);
  assign w_count_inc  = r_count + TAG_W'(1);
  assign w_last       = w_step & (w_count_inc == r_iter_lim);
  assign w_a_op       = r_hold_a ? r_a_data : a_data;
  assign w_b_op       = r_hold_b ? r_b_data : b_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    cfg_ready    = 1'b0;
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) w_state_next = (cfg_iter_lim == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        busy    = 1'b1;
        a_ready = ~r_hold_a;
        b_ready = ~r_hold_b;
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode     <= '0;
      r_tag_a    <= '0;
      r_tag_b    <= '0;
      r_stride_a <= '0;
      r_stride_b <= '0;
      r_iter_lim <= '0;
      r_count    <= '0;
      r_hold_a   <= 1'b0;
      r_hold_b   <= 1'b0;
      r_a_data   <= '0;
      r_b_data   <= '0;
    end else if (w_cfg_accept) begin
      r_mode     <= cfg_mode;
      r_tag_a    <= cfg_tag_a;
      r_tag_b    <= cfg_tag_b;
      r_stride_a <= cfg_stride_a;
      r_stride_b <= cfg_stride_b;
      r_iter_lim <= cfg_iter_lim;
      r_count    <= '0;
      r_hold_a   <= 1'b0;
      r_hold_b   <= 1'b0;
    end else if (w_step) begin
      r_hold_a <= 1'b0;
      r_hold_b <= 1'b0;
      r_tag_a  <= r_tag_a + r_stride_a;
      r_tag_b  <= r_tag_b + r_stride_b;
      r_count  <= w_count_inc;
    end else begin
      if (w_take_a) begin
        r_hold_a <= 1'b1;
        r_a_data <= a_data;
      end
      if (w_take_b) begin
        r_hold_b <= 1'b1;
        r_b_data <= b_data;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(
      .IN_W   (IN_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clear    (w_cfg_accept),
      .step     (w_step),
      .load_out (w_last),
      .mode     (r_mode),
      .a        (w_a_op[i*IN_W +: IN_W]),
      .b        (w_b_op[i*IN_W +: IN_W]),
      .out      (out_data[i*IN_W +: IN_W])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_stripe.sv
`default_nettype none
// ============================================================================
// tb_mac_stripe : randomized and directed self-checking bench for mac_stripe
// Revision : 1.0
// ============================================================================
module tb_mac_stripe;

  localparam int LANES   = 8;
  localparam int IN_W    = 16;
  localparam int FRAC_W  = 14;
  localparam int ACC_W   = 32;
  localparam int TAG_W   = 12;
  localparam int BUS_W   = LANES * IN_W;
  localparam int c_LIMIT = 200;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_mode = '0;
  logic [TAG_W-1:0] cfg_tag_a = '0, cfg_tag_b = '0, cfg_stride_a = '0, cfg_stride_b = '0;
  logic [TAG_W-1:0] cfg_iter_lim = '0;
  logic             a_valid = 1'b0, b_valid = 1'b0;
  logic             a_ready, b_ready;
  logic [TAG_W-1:0] a_tag = '0, b_tag = '0;
  logic [BUS_W-1:0] a_data = '0, b_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [BUS_W-1:0] out_data;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [BUS_W-1:0] qa[$];
  logic [BUS_W-1:0] qb[$];

  always #5 clk = ~clk;

  mac_stripe #(
    .LANES(LANES), .IN_W(IN_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
    .cfg_tag_a(cfg_tag_a), .cfg_tag_b(cfg_tag_b),
    .cfg_stride_a(cfg_stride_a), .cfg_stride_b(cfg_stride_b), .cfg_iter_lim(cfg_iter_lim),
    .a_valid(a_valid), .a_ready(a_ready), .a_tag(a_tag), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_tag(b_tag), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  task automatic check(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint sm_val(input logic [IN_W-1:0] v);
    longint m;
    m = longint'(v[IN_W-2:0]);
    return v[IN_W-1] ? -m : m;
  endfunction

  // Reference: signed integer arithmetic on Q-format values, clamp, then sign-magnitude.
  function automatic logic [BUS_W-1:0] model(input logic [1:0] mode, input int iter);
    logic [BUS_W-1:0] res;
    longint acc_max, acc_min, out_max, one_f, half_f;
    res     = '0;
    acc_max = (longint'(1) << (ACC_W - 1)) - 1;
    acc_min = -acc_max - 1;
    out_max = (longint'(1) << (IN_W - 1)) - 1;
    one_f   = longint'(1) << FRAC_W;
    half_f  = one_f / 2;
    for (int l = 0; l < LANES; l++) begin
      longint acc, mag;
      acc = 0;
      for (int k = 0; k < iter; k++) begin
        longint a, b, d, p, m;
        a = sm_val(qa[k][l*IN_W +: IN_W]);
        b = sm_val(qb[k][l*IN_W +: IN_W]);
        if (mode == 2'd1) d = a + b;
        else if (mode == 2'd2) d = a - b;
        else begin
          p = a * b;
          m = (p < 0) ? -p : p;
          m = (m + half_f) / one_f;
          d = (p < 0) ? -m : m;
        end
        acc = acc + d;
        if (acc > acc_max) acc = acc_max;
        if (acc < acc_min) acc = acc_min;
      end
      mag = (acc < 0) ? -acc : acc;
      if (mag > out_max) mag = out_max;
      res[l*IN_W +: IN_W] = IN_W'(mag);
      if (acc < 0) res[l*IN_W + IN_W - 1] = 1'b1;
    end
    return res;
  endfunction

  function automatic logic [BUS_W-1:0] rand_bus();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_job(input int iter, input logic [IN_W-1:0] av, input logic [IN_W-1:0] bv);
    qa.delete();
    qb.delete();
    repeat (iter) begin
      qa.push_back({LANES{av}});
      qb.push_back({LANES{bv}});
    end
  endtask

  task automatic send_a(input logic [TAG_W-1:0] tag, input logic [BUS_W-1:0] data);
    bit hs;
    hs = 1'b0;
    a_valid = 1'b1; a_tag = tag; a_data = data;
    for (int t = 0; t < c_LIMIT && !hs; t++) begin
      hs = a_ready;
      @(negedge clk);
    end
    a_valid = 1'b0;
    check("a_handshake", BUS_W'(hs), BUS_W'(1));
  endtask

  task automatic send_b(input logic [TAG_W-1:0] tag, input logic [BUS_W-1:0] data);
    bit hs;
    hs = 1'b0;
    b_valid = 1'b1; b_tag = tag; b_data = data;
    for (int t = 0; t < c_LIMIT && !hs; t++) begin
      hs = b_ready;
      @(negedge clk);
    end
    b_valid = 1'b0;
    check("b_handshake", BUS_W'(hs), BUS_W'(1));
  endtask

  task automatic junk_a(input logic [TAG_W-1:0] tag);
    a_valid = 1'b1; a_tag = tag; a_data = rand_bus();
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic junk_b(input logic [TAG_W-1:0] tag);
    b_valid = 1'b1; b_tag = tag; b_data = rand_bus();
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic configure(input logic [1:0] mode, input logic [TAG_W-1:0] ta, input logic [TAG_W-1:0] tb,
                           input logic [TAG_W-1:0] sa, input logic [TAG_W-1:0] sb, input logic [TAG_W-1:0] iter);
    cfg_valid = 1'b1; cfg_mode = mode;
    cfg_tag_a = ta; cfg_tag_b = tb; cfg_stride_a = sa; cfg_stride_b = sb; cfg_iter_lim = iter;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic pop(input string name);
    int t;
    t = 0;
    while (!out_valid && t < c_LIMIT) begin
      @(negedge clk);
      t++;
    end
    check({name, "_pop_valid"}, BUS_W'(out_valid), BUS_W'(1));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_after_pop"}, BUS_W'({out_valid, busy, cfg_ready}), BUS_W'(3'b001));
  endtask

  task automatic run_job(input string name, input logic [1:0] mode,
                         input logic [TAG_W-1:0] ta, input logic [TAG_W-1:0] tb,
                         input logic [TAG_W-1:0] sa, input logic [TAG_W-1:0] sb,
                         input int iter, input bit jitter);
    logic [BUS_W-1:0] exp;
    exp = model(mode, iter);
    configure(mode, ta, tb, sa, sb, TAG_W'(iter));
    check({name, "_busy"}, BUS_W'(busy), BUS_W'(1));
    fork
      begin
        logic [TAG_W-1:0] t;
        t = ta;
        for (int k = 0; k < iter; k++) begin
          if (jitter) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) junk_a(TAG_W'(t + 1));
          end
          send_a(t, qa[k]);
          t = t + sa;
        end
      end
      begin
        logic [TAG_W-1:0] t;
        t = tb;
        for (int k = 0; k < iter; k++) begin
          if (jitter) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) junk_b(TAG_W'(t + 1));
          end
          send_b(t, qb[k]);
          t = t + sb;
        end
      end
    join
    check({name, "_valid"}, BUS_W'(out_valid), BUS_W'(1));
    check({name, "_data"}, out_data, exp);
    pop(name);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_cfg_ready"}, BUS_W'(cfg_ready), BUS_W'(1));
    check({name, "_ab_ready"}, BUS_W'({a_ready, b_ready}), BUS_W'(2'b00));
    check({name, "_out_valid"}, BUS_W'(out_valid), BUS_W'(0));
    check({name, "_busy"}, BUS_W'(busy), BUS_W'(0));
    check({name, "_out_data"}, out_data, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // MAC 1.0 * 0.5 accumulated three times
    set_job(3, 16'h4000, 16'h2000);
    run_job("mac3", 2'd0, 12'h000, 12'h000, 12'h001, 12'h001, 3, 1'b0);

    set_job(1, 16'h0000, 16'h4000);
    run_job("sub1", 2'd2, 12'h005, 12'h00A, 12'h001, 12'h001, 1, 1'b0);
    set_job(1, 16'h8000, 16'h0000);
    run_job("add_negzero", 2'd1, 12'h000, 12'h000, 12'h001, 12'h001, 1, 1'b0);

    // Mismatched A tag 0x011 is dropped; B arrives late so A 0x012 is held
    configure(2'd1, 12'h010, 12'h100, 12'h002, 12'h001, 12'h002);
    fork
      begin
        send_a(12'h010, {LANES{16'h0100}});
        send_a(12'h011, {LANES{16'h1000}});
        send_a(12'h012, {LANES{16'h0200}});
      end
      begin
        send_b(12'h100, '0);
        repeat (2) @(negedge clk);
        send_b(12'h101, '0);
      end
    join
    check("tagdrop_valid", BUS_W'(out_valid), BUS_W'(1));
    check("tagdrop_data", out_data, {LANES{16'h0300}});
    pop("tagdrop");

    qa.delete(); qb.delete();
    qa.push_back({LANES{16'h0001}}); qa.push_back({LANES{16'h0002}});
    qb.push_back('0); qb.push_back('0);
    run_job("tagwrap", 2'd1, 12'hFFF, 12'h000, 12'h002, 12'h000, 2, 1'b0);

    set_job(8, 16'h7FFF, 16'h7FFF);
    run_job("sat_pos", 2'd0, 12'h000, 12'h000, 12'h001, 12'h001, 8, 1'b0);
    set_job(8, 16'h7FFF, 16'hFFFF);
    run_job("sat_neg", 2'd3, 12'h000, 12'h000, 12'h001, 12'h001, 8, 1'b0);

    // B waits in its hold register; then output back-pressure
    configure(2'd0, 12'h000, 12'h000, 12'h001, 12'h001, 12'h001);
    send_b(12'h000, {LANES{16'h2000}});
    check("bheld_b_ready", BUS_W'(b_ready), BUS_W'(0));
    check("bheld_out_valid", BUS_W'(out_valid), BUS_W'(0));
    repeat (2) @(negedge clk);
    check("bheld_still", BUS_W'({b_ready, out_valid, busy}), BUS_W'(3'b001));
    send_a(12'h000, {LANES{16'h4000}});
    check("bheld_valid", BUS_W'(out_valid), BUS_W'(1));
    for (int i = 0; i < 5; i++) begin
      check("stall_data", out_data, {LANES{16'h2000}});
      check("stall_flags", BUS_W'({out_valid, cfg_ready}), BUS_W'(2'b10));
      @(negedge clk);
    end
    pop("stall");

    // Zero iterations goes straight to DONE
    configure(2'd0, 12'h000, 12'h000, 12'h001, 12'h001, 12'h000);
    check("zero_iter_flags", BUS_W'({out_valid, busy, a_ready}), BUS_W'(3'b110));
    pop("zero_iter");

    // Reset in the middle of a four-step job
    set_job(4, 16'h4000, 16'h4000);
    configure(2'd0, 12'h000, 12'h000, 12'h001, 12'h001, 12'h004);
    for (int k = 0; k < 2; k++) begin
      fork
        send_a(TAG_W'(k), qa[k]);
        send_b(TAG_W'(k), qb[k]);
      join
    end
    #2 rst = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_quiet", BUS_W'({out_valid, busy}), BUS_W'(2'b00));
    set_job(2, 16'h2000, 16'hC000);
    run_job("after_reset", 2'd0, 12'h123, 12'h456, 12'h003, 12'h005, 2, 1'b0);

    for (int j = 0; j < 10; j++) begin
      int it;
      it = $urandom_range(1, 6);
      qa.delete(); qb.delete();
      for (int k = 0; k < it; k++) begin
        qa.push_back(rand_bus());
        qb.push_back(rand_bus());
      end
      run_job($sformatf("rand%0d", j), 2'($urandom_range(0, 3)),
              TAG_W'($urandom), TAG_W'($urandom), TAG_W'($urandom), TAG_W'($urandom), it, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
